prio_scan_encoder: RTL

- Parametrised, registered priority encoder that accepts a request vector and emits the index of every set bit, one index per beat, in priority order.
- Uses a valid/ready handshake on both sides.
- Supports either MSB-first or LSB-first priority.
- Sits between request-collection logic (interrupt/status vectors) and a serial consumer that services one source at a time.
- The first beat of each scan equals the classic single-shot priority-encoder result.

---
 rtl/prio_scan_encoder_if.sv | 26 ++
 rtl/prio_scan_encoder.sv | 116 +++++++++++
 2 files changed

// File: rtl/prio_scan_encoder_if.sv
// Handshake bundle for prio_scan_encoder: request vector in, one index per beat out.
interface prio_scan_encoder_if #(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned IDX_W = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_vec;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;
  logic             out_none;
  logic [IDX_W:0]   out_count;

  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_idx, out_last, out_none, out_count
  );

  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_idx, out_last, out_none, out_count
  );
endinterface

// File: rtl/prio_scan_encoder.sv
// Registered priority scan encoder: accepts a request vector and emits the index
// of every set bit, one per beat, in MSB-first or LSB-first priority order.
module prio_scan_encoder #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  localparam int unsigned IDX_W    = $clog2(WIDTH)
) (
  input logic                clk,
  input logic                rst,
  prio_scan_encoder_if.slave bus
);

  typedef logic [WIDTH-1:0] vec_t;
  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [IDX_W:0]   cnt_t;
  typedef enum logic {IDLE, SCAN} state_t;

  function automatic idx_t first_idx(input vec_t v);
    idx_t r;
    r = '0;
    // Later hits overwrite earlier ones, so the scan direction sets priority.
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (MSB_FIRST) begin
        if (v[i]) r = idx_t'(i);
      end else begin
        if (v[WIDTH-1-i]) r = idx_t'(WIDTH-1-i);
      end
    end
    return r;
  endfunction

  function automatic cnt_t popcount(input vec_t v);
    cnt_t c;
    c = '0;
    for (int unsigned i = 0; i < WIDTH; i++) c = c + cnt_t'(v[i]);
    return c;
  endfunction

  state_t state_q, state_d;
  vec_t   pending_q, pending_d;
  logic   valid_q, valid_d;
  idx_t   idx_q, idx_d;
  logic   last_q, last_d;
  logic   none_q, none_d;
  cnt_t   count_q, count_d;
  vec_t   cleared;
  cnt_t   in_cnt;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    valid_d   = valid_q;
    idx_d     = idx_q;
    last_d    = last_q;
    none_d    = none_q;
    count_d   = count_q;
    cleared   = pending_q & ~(vec_t'(1) << idx_q);
    in_cnt    = popcount(bus.in_vec);
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          pending_d = bus.in_vec;
          count_d   = in_cnt;
          idx_d     = first_idx(bus.in_vec);
          last_d    = (in_cnt <= cnt_t'(1));
          none_d    = (bus.in_vec == '0);
          valid_d   = 1'b1;
          state_d   = SCAN;
        end
      end
      SCAN: begin
        if (bus.out_ready) begin
          pending_d = cleared;
          if (last_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            none_d  = 1'b0;
            state_d = IDLE;
          end else begin
            idx_d  = first_idx(cleared);
            last_d = (popcount(cleared) == cnt_t'(1));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      valid_q   <= 1'b0;
      idx_q     <= '0;
      last_q    <= 1'b0;
      none_q    <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      valid_q   <= valid_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      none_q    <= none_d;
      count_q   <= count_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.out_valid = valid_q;
  assign bus.out_idx   = idx_q;
  assign bus.out_last  = last_q;
  assign bus.out_none  = none_q;
  assign bus.out_count = count_q;

endmodule
